// File: rtl/fp_div_24b.sv
// fp_div_24b -- iterative floating-point divider, r = a / b.
//
// Word format: sign | ES-bit exponent (bias 2**(ES-1)-1) | M = N-1-ES mantissa.
// exp==0 is zero (subnormals flush), exp==all-ones is inf (mant==0) or NaN.
// A restoring divider retires one quotient bit per cycle. The result is
// available M+5 cycles after acceptance on the normal path. Special operands
// skip the divider and complete straight from IDLE.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a = dividend, b = divisor)
//   out_valid/out_ready result handshake (r, flags)
//   flags               {invalid, div_by_zero, overflow, underflow}
//
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even.
// Without it the quotient is truncated toward zero.
module fp_div_24b #(
    parameter int N  = 24,
    parameter int ES = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r,
    output logic [3:0]   flags
);
    localparam int M  = N - 1 - ES;
    localparam int QW = M + 3;              // int + M frac + guard + round
    localparam int CW = $clog2(QW);
    localparam logic signed [ES+1:0] BIAS_S  = (ES+2)'(2**(ES-1) - 1);
    localparam logic signed [ES+1:0] EXP_MAX = (ES+2)'(2**ES - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [M+1:0]           rem_q, rem_d;   // one bit wider than the divisor
    logic [M:0]             div_q, div_d;
    logic [QW-1:0]          q_q, q_d;
    logic signed [ES+1:0]   exp_q, exp_d;
    logic                   sign_q, sign_d;
    logic                   ph_q, ph_d;     // NORM: 0 = normalise, 1 = round/pack
    logic [N-1:0]           r_q, r_d;
    logic [3:0]             flags_q, flags_d;

    // Operand classification (only meaningful while IDLE)
    logic [ES-1:0] ea, eb;
    logic [M-1:0]  ma, mb;
    logic          sres, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;

    assign ea     = a[N-2:M];
    assign eb     = b[N-2:M];
    assign ma     = a[M-1:0];
    assign mb     = b[M-1:0];
    assign sres   = a[N-1] ^ b[N-1];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);
    assign special = a_zero | b_zero | (ea == '1) | (eb == '1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            ph_q    <= 1'b0;
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            ph_q    <= ph_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = special ? DONE : DIV;
            DIV:  if (cnt_q == CW'(QW - 1)) state_d = NORM;
            NORM: if (ph_q) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    logic                 ge;
    logic [M+1:0]         rem_sub;
    logic                 inc;
    logic [M+1:0]         mant_r;           // {carry, hidden, frac}
    logic signed [ES+1:0] exp_f;
`ifdef FP_DIV_RNE_EN
    logic                 guard, rnd, sticky, lsb;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        ph_d    = ph_q;
        r_d     = r_q;
        flags_d = flags_q;

        ge      = (rem_q >= {1'b0, div_q});
        rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;

`ifdef FP_DIV_RNE_EN
        lsb    = q_q[2];
        guard  = q_q[1];
        rnd    = q_q[0];
        sticky = |rem_q;
        inc    = guard & (rnd | sticky | lsb);
`else
        inc    = 1'b0;
`endif
        mant_r = {1'b0, q_q[QW-1:2]} + (M+2)'(inc);
        // A rounding carry-out leaves the fraction bits at zero, so only the
        // exponent needs bumping.
        exp_f  = exp_q + (ES+2)'(mant_r[M+1]);

        case (state_q)
            IDLE: if (in_valid) begin
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    r_d     = {1'b0, {ES{1'b1}}, 1'b1, {(M-1){1'b0}}};
                    flags_d = 4'b1000;
                end else if (b_zero) begin
                    r_d     = {sres, {ES{1'b1}}, {M{1'b0}}};
                    flags_d = 4'b0100;
                end else if (a_zero || b_inf) begin
                    r_d     = {sres, {(N-1){1'b0}}};
                    flags_d = 4'b0000;
                end else if (a_inf) begin
                    r_d     = {sres, {ES{1'b1}}, {M{1'b0}}};
                    flags_d = 4'b0000;
                end else begin
                    sign_d = sres;
                    exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
                    rem_d  = {2'b01, ma};
                    div_d  = {1'b1, mb};
                    q_d    = '0;
                    cnt_d  = '0;
                    ph_d   = 1'b0;
                end
            end
            DIV: begin
                q_d   = {q_q[QW-2:0], ge};
                rem_d = rem_sub << 1;
                cnt_d = cnt_q + CW'(1);
            end
            NORM: begin
                if (!ph_q) begin
                    // Quotient of two [1,2) mantissas lies in (0.5,2)
                    if (!q_q[QW-1]) begin
                        q_d   = q_q << 1;
                        exp_d = exp_q - (ES+2)'(1);
                    end
                    ph_d = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    if (exp_f >= EXP_MAX) begin
                        r_d     = {sign_q, {ES{1'b1}}, {M{1'b0}}};
                        flags_d = 4'b0010;
                    end else if (exp_f <= $signed((ES+2)'(0))) begin
                        r_d     = {sign_q, {(N-1){1'b0}}};
                        flags_d = 4'b0001;
                    end else begin
                        r_d     = {sign_q, exp_f[ES-1:0], mant_r[M-1:0]};
                        flags_d = 4'b0000;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        r         = r_q;
        flags     = flags_q;
    end
endmodule

// File: tb/tb_fp_div_24b.sv
module tb_fp_div_24b;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        in_ready, out_valid;
    logic [23:0] r;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    fp_div_24b dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .r(r), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation, wait for the result, check it. elat<0 skips the
    // latency check. rel=1 hands the result off afterwards.
    task automatic run_op(input string tag, input logic [23:0] av, input logic [23:0] bv,
                          input logic [23:0] er, input logic [3:0] ef,
                          input int elat, input bit rel);
        int lat;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (elat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    logic [23:0] r_1over3;
    logic        seen;

    initial begin
`ifdef FP_DIV_RNE_EN
        r_1over3 = 24'h3AAAAB;
`else
        r_1over3 = 24'h3AAAAA;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);

        // Normal path
        run_op("6div3",   24'h430000, 24'h410000, 24'h400000, 4'b0000, 22, 1'b1);
        run_op("1div3",   24'h3E0000, 24'h410000, r_1over3,   4'b0000, 22, 1'b1);
        run_op("m2div1",  24'hC00000, 24'h3E0000, 24'hC00000, 4'b0000, 22, 1'b1);
        // Special cases
        run_op("1div0",   24'h3E0000, 24'h000000, 24'h7E0000, 4'b0100, -1, 1'b1);
        run_op("0div0",   24'h000000, 24'h000000, 24'h7F0000, 4'b1000, -1, 1'b1);
        run_op("0divm3",  24'h000000, 24'hC10000, 24'h800000, 4'b0000, -1, 1'b1);
        run_op("infdivm1",24'h7E0000, 24'hBE0000, 24'hFE0000, 4'b0000, -1, 1'b1);
        // Range limits
        run_op("ovf",     24'h7DFFFF, 24'h020000, 24'h7E0000, 4'b0010, 22, 1'b1);
        run_op("unf",     24'h020000, 24'h7DFFFF, 24'h000000, 4'b0001, 22, 1'b1);

        // Output hold with ignored in_valid pulses
        run_op("hold", 24'h430000, 24'h410000, 24'h400000, 4'b0000, 22, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 24'h3E0000; b = 24'h000000;
            @(negedge clk);
            chk("hold_r", 32'(r), 32'h400000);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("hold_release", 32'(in_ready), 32'd1);
        run_op("after_hold", 24'hC00000, 24'h3E0000, 24'hC00000, 4'b0000, 22, 1'b1);

        // Reset in the middle of a divide
        @(negedge clk);
        a = 24'h3E0000; b = 24'h410000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_r", 32'(r), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run_op("after_rst", 24'h430000, 24'h410000, 24'h400000, 4'b0000, 22, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
